// File: rtl/instr_fetch_if.sv
// Fetch unit bus: instruction pointer, memory read port and decoder handshake.
// master = fetch unit, slave = pointer/memory/decoder side.
interface instr_fetch_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] ip;
    logic [WORD_SIZE-1:0] ip_adj;
    logic                 ip_update;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 branch_taken;
    logic [WORD_SIZE-1:0] branch_offset;

    modport master (
        input  ip,
        output ip_adj,
        output ip_update,
        output mem_addr,
        output mem_req,
        input  mem_data,
        input  mem_ack,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  branch_taken,
        input  branch_offset
    );

    modport slave (
        output ip,
        input  ip_adj,
        input  ip_update,
        input  mem_addr,
        input  mem_req,
        output mem_data,
        output mem_ack,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output branch_taken,
        output branch_offset
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> REQ -> HOLD -> REQ, one word per ack.
// Tracks the pointer through ip_update/ip_adj pulses (+1 per word, offset on branch).
module instr_fetch #(
    parameter int WORD_SIZE = 16
) (
    input  logic          clk,
    input  logic          reset_enable,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

    state_t               state;
    logic [WORD_SIZE-1:0] fetch_addr;
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] adj;
    logic                 req;
    logic                 valid;
    logic                 update;
    logic                 handshake;

    assign handshake = valid && bus.instr_ready;

    // Fetch state machine with registered memory, decoder and pointer outputs.
    always_ff @(posedge clk) begin
        if (reset_enable) begin
            state      <= IDLE;
            fetch_addr <= '0;
            req        <= 1'b0;
            valid      <= 1'b0;
            instr      <= '0;
            update     <= 1'b0;
            adj        <= '0;
        end else begin
            update <= 1'b0;
            adj    <= '0;
            unique case (state)
                IDLE: begin
                    fetch_addr <= bus.ip;
                    req        <= 1'b1;
                    state      <= REQ;
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        instr      <= bus.mem_data;
                        valid      <= 1'b1;
                        fetch_addr <= fetch_addr + ONE;
                        update     <= 1'b1;
                        adj        <= ONE;
                        req        <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        valid <= 1'b0;
                        req   <= 1'b1;
                        state <= REQ;
                        if (bus.branch_taken) begin
                            fetch_addr <= fetch_addr + bus.branch_offset;
                            update     <= 1'b1;
                            adj        <= bus.branch_offset;
                        end
                    end
                end
                default: begin
                    req   <= 1'b0;
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr    = fetch_addr;
    assign bus.mem_req     = req;
    assign bus.instr       = instr;
    assign bus.instr_valid = valid;
    assign bus.ip_update   = update;
    assign bus.ip_adj      = adj;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model, pointer model,
// expected-word and expected-adjust queues checked by a negedge monitor.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ip_val;
    logic [15:0] ip_init = 16'h0;
    int          checks = 0;
    int          failures = 0;
    int          hs_cnt = 0;
    int          lat = 0;
    int          mode = 0;
    logic        man_ack = 1'b0;
    logic [15:0] man_data = 16'h0;
    logic [15:0] exp_q[$];
    logic [15:0] adj_q[$];

    instr_fetch_if #(.WORD_SIZE(16)) bus();

    instr_fetch #(.WORD_SIZE(16)) dut (
        .clk(clk),
        .reset_enable(rst),
        .bus(bus)
    );

    assign bus.ip = ip_val;

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Instruction pointer: loads ip_init in reset, follows update pulses.
    initial forever begin
        @(posedge clk);
        if (rst) ip_val <= ip_init;
        else if (bus.ip_update) ip_val <= ip_val + bus.ip_adj;
    end

    // Memory: mode 0 never acks, 1 acks after lat extra cycles, 2 manual.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 2) begin
                bus.mem_ack  = man_ack;
                bus.mem_data = man_data;
            end else if (mode == 1 && bus.mem_req) begin
                bus.mem_data = bus.mem_addr + 16'h0100;
                if (cnt == lat) begin
                    bus.mem_ack = 1'b1;
                    cnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                bus.mem_ack  = 1'b0;
                bus.mem_data = 16'h0;
                cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops plus request/ack protocol checks.
    initial begin
        logic        p_rst;
        logic        p_req;
        logic        p_ack;
        logic [15:0] p_addr;
        logic [15:0] p_data;
        p_rst = 1'b1;
        p_req = 1'b0;
        p_ack = 1'b0;
        p_addr = 16'h0;
        p_data = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.instr_valid && bus.instr_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL hs_extra: got %h expected none", bus.instr);
                    end else begin
                        chk("instr", bus.instr, exp_q.pop_front());
                    end
                end
                if (bus.ip_update) begin
                    if (adj_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL upd_extra: got %h expected none", bus.ip_adj);
                    end else begin
                        chk("ip_adj", bus.ip_adj, adj_q.pop_front());
                    end
                end else begin
                    chk("ip_adj_idle", bus.ip_adj, 16'h0);
                end
                if (!p_rst && p_req && !p_ack) begin
                    chk("req_hold", 16'(bus.mem_req), 16'h1);
                    chk("addr_hold", bus.mem_addr, p_addr);
                end
                if (!p_rst && p_req && p_ack) begin
                    chk("valid_after_ack", 16'(bus.instr_valid), 16'h1);
                    chk("instr_after_ack", bus.instr, p_data);
                end
                if (bus.mem_req && !bus.ip_update)
                    chk("lockstep", bus.mem_addr, ip_val);
            end
            p_rst  = rst;
            p_req  = bus.mem_req;
            p_ack  = bus.mem_ack;
            p_addr = bus.mem_addr;
            p_data = bus.mem_data;
        end
    end

    task automatic start_reset(input logic [15:0] ip0);
        rst = 1'b1;
        ip_init = ip0;
        bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_offset = 16'h0;
        tick(2);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.instr_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.instr_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: got timeout expected instr_valid", name);
        end
    endtask

    task automatic wait_hs(input int target, output int n);
        n = 0;
        while (hs_cnt < target && n < 40) begin
            tick();
            n++;
        end
        if (hs_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL hs_wait: got %0d expected %0d", hs_cnt, target);
        end
    endtask

    initial begin
        int n;
        int base;
        bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_offset = 16'h0;

        // Reset values
        mode = 1;
        lat = 0;
        start_reset(16'h0000);
        tick();
        chk("rst_valid", 16'(bus.instr_valid), 16'h0);
        chk("rst_req", 16'(bus.mem_req), 16'h0);
        chk("rst_update", 16'(bus.ip_update), 16'h0);
        chk("rst_adj", bus.ip_adj, 16'h0);
        chk("rst_instr", bus.instr, 16'h0);

        // 1: single-cycle memory, ready high, one word every 2 cycles
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0102);
        repeat (4) adj_q.push_back(16'h0001);
        bus.instr_ready = 1'b1;
        base = hs_cnt;
        rst = 1'b0;
        wait_hs(base + 3, n);
        chk("t1_cycles", 16'(n), 16'd7);
        bus.instr_ready = 1'b0;

        // 3: decoder stalls 5 cycles
        wait_valid("t3_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t3_instr", bus.instr, 16'h0103);
            chk("t3_valid", 16'(bus.instr_valid), 16'h1);
            chk("t3_req", 16'(bus.mem_req), 16'h0);
            tick();
        end
        exp_q.push_back(16'h0103);
        bus.instr_ready = 1'b1;
        tick();
        chk("t3_next_req", 16'(bus.mem_req), 16'h1);
        chk("t3_next_addr", bus.mem_addr, 16'h0004);
        bus.instr_ready = 1'b0;
        mode = 0;

        // 2: memory acks 3 cycles after request
        start_reset(16'h0020);
        mode = 1;
        lat = 2;
        adj_q.push_back(16'h0001);
        exp_q.push_back(16'h0120);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req", 16'(bus.mem_req), 16'h1);
            chk("t2_addr", bus.mem_addr, 16'h0020);
            chk("t2_novalid", 16'(bus.instr_valid), 16'h0);
        end
        tick();
        chk("t2_valid", 16'(bus.instr_valid), 16'h1);
        chk("t2_instr", bus.instr, 16'h0120);
        mode = 0;
        lat = 0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;

        // 4: taken branch from next address 0x0011 by -16
        start_reset(16'h0010);
        mode = 1;
        adj_q.push_back(16'h0001);
        exp_q.push_back(16'h0110);
        rst = 1'b0;
        wait_valid("t4_valid");
        bus.branch_taken = 1'b1;
        bus.branch_offset = 16'h0005;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_nohs_update", 16'(bus.ip_update), 16'h0);
            chk("t4_nohs_valid", 16'(bus.instr_valid), 16'h1);
        end
        bus.branch_offset = 16'hFFF0;
        bus.instr_ready = 1'b1;
        adj_q.push_back(16'hFFF0);
        adj_q.push_back(16'h0001);
        exp_q.push_back(16'h0101);
        tick();
        chk("t4_update", 16'(bus.ip_update), 16'h1);
        chk("t4_adj", bus.ip_adj, 16'hFFF0);
        chk("t4_addr", bus.mem_addr, 16'h0001);
        bus.branch_taken = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        mode = 0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;

        // 5: fetch at 0xFFFF wraps to 0x0000
        start_reset(16'hFFFF);
        mode = 1;
        adj_q.push_back(16'h0001);
        adj_q.push_back(16'h0001);
        exp_q.push_back(16'h00FF);
        rst = 1'b0;
        wait_valid("t5_valid");
        bus.instr_ready = 1'b1;
        tick();
        chk("t5_wrap_req", 16'(bus.mem_req), 16'h1);
        chk("t5_wrap_addr", bus.mem_addr, 16'h0000);
        bus.instr_ready = 1'b0;
        tick(2);

        // 6: reset during REQ with a same-cycle ack
        mode = 2;
        man_ack = 1'b0;
        start_reset(16'h0040);
        rst = 1'b0;
        tick();
        chk("t6_req", 16'(bus.mem_req), 16'h1);
        chk("t6_addr", bus.mem_addr, 16'h0040);
        man_ack = 1'b1;
        man_data = 16'hBEEF;
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 16'(bus.instr_valid), 16'h0);
        chk("t6_rst_req", 16'(bus.mem_req), 16'h0);
        chk("t6_rst_instr", bus.instr, 16'h0);
        chk("t6_rst_update", 16'(bus.ip_update), 16'h0);
        man_ack = 1'b0;
        ip_init = 16'h0055;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_req", 16'(bus.mem_req), 16'h1);
        chk("t6_idle_addr", bus.mem_addr, 16'h0055);
        chk("t6_idle_valid", 16'(bus.instr_valid), 16'h0);
        adj_q.push_back(16'h0001);
        exp_q.push_back(16'h0155);
        mode = 1;
        bus.instr_ready = 1'b1;
        base = hs_cnt;
        wait_hs(base + 1, n);
        mode = 0;
        bus.instr_ready = 1'b0;
        tick(3);

        chk("exp_q_empty", 16'(exp_q.size()), 16'h0);
        chk("adj_q_empty", 16'(adj_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
